// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared counter encodings and saturating update for the branch predictor
package bpred_pkg;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Two-bit saturating step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken)
      return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    else
      return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  function automatic logic ctr_dir(input logic [1:0] c);
    return c[1];
  endfunction

endpackage

// File: rtl/bpred_fifo.sv
// rtl/bpred_fifo.sv - in-order queue of outstanding predictions, power-of-two depth
module bpred_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bpred_ctrl.sv
// rtl/bpred_ctrl.sv - 2-bit counter branch predictor with in-order resolution queue
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [IDX_W-1:0]       req_idx,
  output logic                   req_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   mispredict,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int EW      = IDX_W + 1;

  logic [1:0]       tbl [ENTRIES];
  logic             accept;
  logic             resolve;
  logic             lookup_dir;
  logic             q_full;
  logic             q_empty;
  logic [EW-1:0]    q_push_data;
  logic [EW-1:0]    q_pop_data;
  logic [IDX_W-1:0] pop_idx;
  logic             pop_pred;

  // Full flag is derived purely from the registered queue count.
  assign req_ready   = ~q_full;
  assign accept      = req_valid & req_ready;
  assign resolve     = res_valid & ~q_empty;
  assign lookup_dir  = ctr_dir(tbl[req_idx]);
  assign q_push_data = {req_idx, lookup_dir};
  assign pop_idx     = q_pop_data[EW-1:1];
  assign pop_pred    = q_pop_data[0];

  bpred_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (q_push_data),
    .pop       (resolve),
    .pop_data  (q_pop_data),
    .full      (q_full),
    .empty     (q_empty),
    .count     (count)
  );

  // Lookup reads the table combinationally before this edge's update lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= CTR_WNT;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pred_valid <= accept;
      pred_taken <= accept & lookup_dir;
      mispredict <= resolve & (pop_pred != res_taken);
      res_err    <= res_valid & q_empty;
      if (resolve) tbl[pop_idx] <= ctr_next(tbl[pop_idx], res_taken);
    end
  end

endmodule

// File: tb/tb_bpred_ctrl.sv
// tb/tb_bpred_ctrl.sv - directed self-checking bench for bpred_ctrl
module tb_bpred_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_idx = '0;
  logic       req_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic       mispredict;
  logic       res_err;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  bpred_ctrl #(.IDX_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .mispredict (mispredict),
    .res_err    (res_err),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [3:0] idx);
    req_valid = 1'b1;
    req_idx   = idx;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    res_valid = 1'b1;
    res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_count", count, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_res_err", res_err, 0);
    rst = 1'b0;
    chk("ready_after_rst", req_ready, 1);

    // first lookup on a fresh counter predicts not-taken
    lookup(4'd3);
    chk("first_pred_valid", pred_valid, 1);
    chk("first_pred_taken", pred_taken, 0);
    chk("first_count", count, 1);
    tick();
    chk("pred_valid_one_cycle", pred_valid, 0);
    resolve(1'b0);
    chk("nt_resolve_mispredict", mispredict, 0);
    chk("nt_resolve_count", count, 0);

    // idx5 trained taken twice: 1 -> 2 -> 3
    lookup(4'd5);
    chk("idx5_pred1", pred_taken, 0);
    resolve(1'b1);
    chk("idx5_mp1", mispredict, 1);
    chk("idx5_count1", count, 0);
    tick();
    chk("idx5_mp1_pulse", mispredict, 0);
    lookup(4'd5);
    chk("idx5_pred2", pred_taken, 1);
    resolve(1'b1);
    chk("idx5_mp2", mispredict, 0);
    lookup(4'd5);
    chk("idx5_pred3", pred_taken, 1);
    resolve(1'b0);
    chk("idx5_mp3", mispredict, 1);

    // fill the queue; counters: 0,1,2 at 1 and 3 at 0
    for (int i = 0; i < 4; i++) begin
      lookup(4'(i));
      chk("fill_pred", pred_taken, 0);
    end
    chk("full_count", count, 4);
    chk("full_ready", req_ready, 0);
    lookup(4'd7);
    chk("full_ignored_pv", pred_valid, 0);
    chk("full_ignored_count", count, 4);
    resolve(1'b1);
    chk("unfull_mp", mispredict, 1);
    chk("unfull_count", count, 3);
    chk("unfull_ready", req_ready, 1);
    resolve(1'b0);
    chk("drain_idx1_mp", mispredict, 0);
    chk("drain_idx1_count", count, 2);

    // queue now holds idx2, idx3; lookup idx2 while resolving idx2 taken
    req_valid = 1'b1;
    req_idx   = 4'd2;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    req_valid = 1'b0;
    res_valid = 1'b0;
    chk("rbw_pred_valid", pred_valid, 1);
    chk("rbw_pred_taken", pred_taken, 0);
    chk("rbw_mispredict", mispredict, 1);
    chk("rbw_count", count, 2);
    resolve(1'b0);
    chk("rbw_idx3_mp", mispredict, 0);
    chk("rbw_idx3_count", count, 1);
    lookup(4'd2);
    chk("rbw_after_pred", pred_taken, 1);
    chk("rbw_after_count", count, 2);
    resolve(1'b0);
    chk("rbw_pop_a_mp", mispredict, 0);
    resolve(1'b0);
    chk("rbw_pop_b_mp", mispredict, 1);
    chk("rbw_drained", count, 0);

    // resolve with nothing outstanding
    resolve(1'b1);
    chk("err_pulse", res_err, 1);
    chk("err_no_mp", mispredict, 0);
    chk("err_count", count, 0);
    tick();
    chk("err_one_cycle", res_err, 0);
    lookup(4'd5);
    chk("err_idx5_kept", pred_taken, 1);
    lookup(4'd0);
    chk("err_idx0_kept", pred_taken, 1);
    lookup(4'd6);
    chk("err_idx6_kept", pred_taken, 0);
    chk("pre_rst_count", count, 3);

    // reset beats a simultaneous lookup and resolve
    req_valid = 1'b1;
    req_idx   = 4'd6;
    res_valid = 1'b1;
    res_taken = 1'b1;
    rst       = 1'b1;
    tick();
    chk("mid_rst_pred_valid", pred_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_mp", mispredict, 0);
    chk("mid_rst_err", res_err, 0);
    rst       = 1'b0;
    req_valid = 1'b0;
    res_valid = 1'b0;
    tick();
    chk("post_rst_pred_valid", pred_valid, 0);
    chk("post_rst_count", count, 0);

    // every counter must be exactly 1: predicts 0, one taken step flips it
    for (int i = 0; i < 16; i++) begin
      lookup(4'(i));
      chk("rst_ctr_lo", pred_taken, 0);
      resolve(1'b1);
      lookup(4'(i));
      chk("rst_ctr_hi", pred_taken, 1);
      resolve(1'b0);
    end
    chk("final_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpred_ctrl.md
BPRED_CTRL -- requirements
Module: bpred_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning counter-table index width (2**IDX_W entries).
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum outstanding (unresolved) predictions; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  lookup request.
REQ-006 SHALL have port req_idx  input  IDX_W  table index of the branch being looked up.
REQ-007 SHALL have port req_ready  output  1  lookup accepted this cycle when high together with req_valid.
REQ-008 SHALL have port pred_valid  output  1  prediction strobe, one cycle.
REQ-009 SHALL have port pred_taken  output  1  predicted direction, valid with pred_valid.
REQ-010 SHALL have port res_valid  input  1  resolution of the oldest outstanding branch.
REQ-011 SHALL have port res_taken  input  1  actual direction for that resolution.
REQ-012 SHALL have port mispredict  output  1  one-cycle pulse: resolved direction differed from prediction.
REQ-013 SHALL have port res_err  output  1  one-cycle pulse: res_valid arrived with no outstanding branch.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of outstanding predictions.

Function
REQ-015 SHALL hold one 2-bit saturating counter per index, encoded 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken.
REQ-016 SHALL drive req_ready = (count < DEPTH), combinationally from registered count only.
REQ-017 SHALL, on accept (req_valid & req_ready), assert pred_valid exactly one cycle later with pred_taken = bit 1 of the counter at req_idx as read in the accept cycle.
REQ-018 SHALL, on accept, push {req_idx, predicted direction} into an in-order queue; no accept, no push.
REQ-019 SHALL, on res_valid with count > 0, pop the oldest entry and write its counter: taken -> min(c+1,3), not taken -> max(c-1,0); the write is visible from the next cycle.
REQ-020 SHALL pulse mispredict one cycle after the resolving cycle when popped prediction != res_taken; otherwise hold it 0.
REQ-021 SHALL, on res_valid with count == 0, leave table and queue unchanged and pulse res_err one cycle later.
REQ-022 SHALL, for accept and resolve in the same cycle, perform both; count unchanged; the lookup reads the pre-update counter even at the same index (read-before-write).
REQ-023 SHALL, when count == DEPTH, refuse lookups (req_ready 0) but still accept a same-cycle resolve; ready rises the following cycle.
REQ-024 SHALL wrap queue read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-025 SHALL keep pred_valid, mispredict, res_err low in every cycle not specified above.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set every counter to 1 (weak-not-taken), empty the queue (count 0), and drive pred_valid, pred_taken, mispredict, res_err to 0.
REQ-027 SHALL give rst priority over simultaneous req_valid/res_valid; requests and resolutions presented during reset are discarded, and predictions pending at reset are never emitted.
REQ-028 SHALL have req_ready high in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place the four counter-state constants and the saturating-update next-state function in shared package bpred_pkg.
REQ-030 SHALL implement the outstanding queue as sub-module bpred_fifo (parameterised width and depth, push/pop/full/empty/count, synchronous active-high reset).

Verification
REQ-031 Reset, then lookup idx 3 -> pred_valid one cycle later, pred_taken 0; count 1.
REQ-032 Two lookup+resolve(taken) sequences on idx 5 -> third lookup predicts taken (counter 1->2->3); mispredict pulses on the first resolve only.
REQ-033 Four lookups without resolve (DEPTH 4) -> req_ready 0, fifth req_valid ignored; one resolve -> req_ready 1 next cycle, count 3.
REQ-034 Same cycle: lookup idx 2 and resolve(taken) of outstanding idx 2 at counter 1 -> lookup predicts 0, counter becomes 2 afterward, count unchanged.
REQ-035 res_valid with count 0 -> res_err pulse one cycle later, counters unchanged.
REQ-036 Assert rst with 3 outstanding and a pending pred_valid -> pred_valid 0, count 0, all counters 1.
